// File: rtl/char_pixel_gen.sv
// char_pixel_gen
// Text-mode pixel generator. Maps the beam position to a text-buffer address,
// maps the returned character plus glyph row to an 8x16 font address, then
// selects one pixel of the returned glyph row. hsync/vsync/active are
// delayed to match the 5-cycle pipeline.
//
// Optional feature macro: CURSOR_EN
//   When defined, a blinking underline cursor (glyph rows 14-15 of the
//   cursor cell) inverts the pixel. When undefined, the cursor ports are
//   ignored and no blink logic is built.
//
// Ports:
//   clk_i, rstn_i               pixel clock, asynchronous active-low reset
//   hcount_i, vcount_i          beam position
//   active_i, hsync_i, vsync_i  visible-area flag and raw syncs
//   tbuf_addr_o / tbuf_data_i   text buffer (synchronous read, 1-cycle latency)
//   font_addr_o / font_data_i   font memory (synchronous read, 1-cycle latency)
//   cursor_col_i, cursor_row_i  cursor cell position (CURSOR_EN only)
//   pixel_o                     pixel on/off
//   hsync_o, vsync_o, active_o  inputs delayed by 5 cycles
module char_pixel_gen #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CNT_WIDTH    = 10,
  parameter int TADDR_WIDTH  = 12,
  parameter int FADDR_WIDTH  = 11,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [CNT_WIDTH-1:0]   hcount_i,
  input  logic [CNT_WIDTH-1:0]   vcount_i,
  input  logic                   active_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  output logic [TADDR_WIDTH-1:0] tbuf_addr_o,
  input  logic [7:0]             tbuf_data_i,
  output logic [FADDR_WIDTH-1:0] font_addr_o,
  input  logic [7:0]             font_data_i,
  input  logic [6:0]             cursor_col_i,
  input  logic [4:0]             cursor_row_i,
  output logic                   pixel_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   active_o
);

  localparam int COL_W = CNT_WIDTH - 3;
  localparam int ROW_W = CNT_WIDTH - 4;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [2:0]       px;
  logic [3:0]       gy;

  assign col = hcount_i[CNT_WIDTH-1:3];
  assign row = vcount_i[CNT_WIDTH-1:4];
  assign px  = hcount_i[2:0];
  assign gy  = vcount_i[3:0];

  logic [TADDR_WIDTH-1:0] row_x_cols;
  logic [TADDR_WIDTH-1:0] tbuf_addr_d, tbuf_addr_q;
  logic [FADDR_WIDTH-1:0] font_addr_d, font_addr_q;
  logic                   pixel_d, pixel_q;
  logic [2:0]             px1_q, px2_q, px3_q, px4_q;
  logic [3:0]             gy1_q, gy2_q;
  logic                   inv3_q, inv4_q;
  // Bit k holds the input delayed by k+1 cycles.
  logic [4:0]             act_q, hsync_q, vsync_q;
  logic                   cur4;

  // Row base address; the 80-column case uses two shifts instead of a multiplier.
  // Results wrap modulo 2^TADDR_WIDTH by design.
  generate
    if (COLS == 80) begin : g_mul80
      assign row_x_cols = (TADDR_WIDTH'(row) << 6) + (TADDR_WIDTH'(row) << 4);
    end else begin : g_mul
      assign row_x_cols = TADDR_WIDTH'(row) * TADDR_WIDTH'(COLS);
    end
  endgenerate

  always_comb begin
    tbuf_addr_d = '0;
    if (active_i) begin
      tbuf_addr_d = row_x_cols + TADDR_WIDTH'(col);
    end
    font_addr_d = FADDR_WIDTH'({tbuf_data_i[6:0], gy2_q});
    pixel_d     = act_q[3] & (font_data_i[px4_q] ^ inv4_q ^ cur4);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tbuf_addr_q <= '0;
      font_addr_q <= '0;
      pixel_q     <= 1'b0;
      px1_q       <= '0;
      px2_q       <= '0;
      px3_q       <= '0;
      px4_q       <= '0;
      gy1_q       <= '0;
      gy2_q       <= '0;
      inv3_q      <= 1'b0;
      inv4_q      <= 1'b0;
      act_q       <= '0;
      hsync_q     <= '0;
      vsync_q     <= '0;
    end else begin
      tbuf_addr_q <= tbuf_addr_d;
      font_addr_q <= font_addr_d;
      pixel_q     <= pixel_d;
      px1_q       <= px;
      px2_q       <= px1_q;
      px3_q       <= px2_q;
      px4_q       <= px3_q;
      gy1_q       <= gy;
      gy2_q       <= gy1_q;
      inv3_q      <= tbuf_data_i[7];
      inv4_q      <= inv3_q;
      act_q       <= {act_q[3:0], active_i};
      hsync_q     <= {hsync_q[3:0], hsync_i};
      vsync_q     <= {vsync_q[3:0], vsync_i};
    end
  end

`ifdef CURSOR_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] frame_cnt_d, frame_cnt_q;
  logic               blink_d, blink_q;
  logic               vsync_prev_q;
  logic               cell_hit;
  logic [3:0]         cur_q;
  logic               unused_sink;

  // Frames are counted on the falling edge of the raw (active-low) vsync;
  // blink_q toggles every BLINK_FRAMES frames.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vsync_prev_q && !vsync_i) begin
      if (frame_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Underline on glyph rows 14 and 15 of the cursor cell while blink is on.
  assign cell_hit = blink_q
                  && (col == COL_W'(cursor_col_i))
                  && (row == ROW_W'(cursor_row_i))
                  && (gy[3:1] == 3'b111);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_cnt_q  <= '0;
      blink_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      cur_q        <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      blink_q      <= blink_d;
      vsync_prev_q <= vsync_i;
      cur_q        <= {cur_q[2:0], cell_hit};
    end
  end

  assign cur4        = cur_q[3];
  assign unused_sink = ^{32'(ROWS)};
`else
  logic unused_sink;

  assign cur4 = 1'b0;
  // Cursor ports and blink/row parameters have no role without the cursor.
  assign unused_sink = ^{cursor_col_i, cursor_row_i, 32'(ROWS), 32'(BLINK_FRAMES)};
`endif

  assign tbuf_addr_o = tbuf_addr_q;
  assign font_addr_o = font_addr_q;
  assign pixel_o     = pixel_q;
  assign hsync_o     = hsync_q[4];
  assign vsync_o     = vsync_q[4];
  assign active_o    = act_q[4];

endmodule

// File: tb/tb_char_pixel_gen.sv
// tb_char_pixel_gen
// Self-checking bench for char_pixel_gen. Sync-read models of the text buffer
// and font memory answer the DUT's addresses; every driven cycle pushes its
// expected addresses and outputs onto a scoreboard that a monitor pops at the
// matching pipeline stage. Scenario tasks add their own targeted checks.
module tb_char_pixel_gen;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [9:0]  hcount_i, vcount_i;
  logic        active_i, hsync_i, vsync_i;
  logic [11:0] tbuf_addr_o;
  logic [7:0]  tbuf_data_i;
  logic [10:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic [6:0]  cursor_col_i = 7'd2;
  logic [4:0]  cursor_row_i = 5'd2;
  logic        pixel_o, hsync_o, vsync_o, active_o;

  int checks = 0;
  int errors = 0;
  int unsigned cycCount = 0;

  logic [7:0] tbufMem [0:4095];
  logic [7:0] fontMem [0:2047];

  typedef struct {
    int unsigned cyc;
    logic [11:0] taddr;
    logic [10:0] faddr;
    logic [3:0]  outs;
  } sbItem_t;

  sbItem_t sbQ[$];

`ifdef CURSOR_EN
  logic modelBlink  = 1'b0;
  int   modelFrame  = 0;
  logic modelPrevVs = 1'b0;
`endif

  char_pixel_gen dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .hcount_i     (hcount_i),
    .vcount_i     (vcount_i),
    .active_i     (active_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .tbuf_addr_o  (tbuf_addr_o),
    .tbuf_data_i  (tbuf_data_i),
    .font_addr_o  (font_addr_o),
    .font_data_i  (font_data_i),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
    .pixel_o      (pixel_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .active_o     (active_o)
  );

  always #20 clk_i = ~clk_i;

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk_i) begin
    tbuf_data_i <= tbufMem[tbuf_addr_o];
    font_data_i <= fontMem[font_addr_o];
  end

  // Scoreboard monitor: an item sampled on posedge n is checked for
  // tbuf_addr_o after n, font_addr_o after n+2 and the outputs after n+4.
  always @(posedge clk_i) begin
    cycCount++;
    #1;
    for (int i = 0; i < sbQ.size(); i++) begin
      if (sbQ[i].cyc == cycCount) begin
        checks++;
        if (tbuf_addr_o !== sbQ[i].taddr) begin
          errors++;
          $display("[TB] FAIL sb_tbuf_addr cyc=%0d got=%0d exp=%0d", cycCount, tbuf_addr_o, sbQ[i].taddr);
        end
      end
      if (sbQ[i].cyc + 2 == cycCount) begin
        checks++;
        if (font_addr_o !== sbQ[i].faddr) begin
          errors++;
          $display("[TB] FAIL sb_font_addr cyc=%0d got=%h exp=%h", cycCount, font_addr_o, sbQ[i].faddr);
        end
      end
    end
    if (sbQ.size() > 0 && sbQ[0].cyc + 4 == cycCount) begin
      checks++;
      if ({pixel_o, hsync_o, vsync_o, active_o} !== sbQ[0].outs) begin
        errors++;
        $display("[TB] FAIL sb_outputs(pix,hs,vs,act) cyc=%0d got=%b exp=%b", cycCount,
                 {pixel_o, hsync_o, vsync_o, active_o}, sbQ[0].outs);
      end
      void'(sbQ.pop_front());
    end
  end

  // Drive one cycle of raster input and push its expected results.
  task automatic step(input int h, input int v, input logic act, input logic hs, input logic vs);
    sbItem_t    it;
    logic [7:0] ch;
    logic [7:0] frow;
    logic       cur;
    int         taddr;
    @(negedge clk_i);
    hcount_i = 10'(h);
    vcount_i = 10'(v);
    active_i = act;
    hsync_i  = hs;
    vsync_i  = vs;
    taddr    = act ? (((v / 16) * 80 + (h / 8)) % 4096) : 0;
    ch       = tbufMem[taddr];
    it.faddr = {ch[6:0], 4'(v % 16)};
    frow     = fontMem[it.faddr];
    cur      = 1'b0;
`ifdef CURSOR_EN
    cur = modelBlink && ((h / 8) == int'(cursor_col_i)) && ((v / 16) == int'(cursor_row_i))
          && ((v % 16) >= 14);
    if (modelPrevVs && !vs) begin
      if (modelFrame == 15) begin
        modelFrame = 0;
        modelBlink = ~modelBlink;
      end else begin
        modelFrame++;
      end
    end
    modelPrevVs = vs;
`endif
    it.cyc   = cycCount + 1;
    it.taddr = 12'(taddr);
    it.outs  = {act & (frow[h % 8] ^ ch[7] ^ cur), hs, vs, act};
    sbQ.push_back(it);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      hcount_i = 10'($urandom);
      vcount_i = 10'($urandom);
      active_i = 1'($urandom);
      hsync_i  = 1'($urandom);
      vsync_i  = 1'($urandom);
      #5;
      checks++;
      if ({tbuf_addr_o, font_addr_o, pixel_o, hsync_o, vsync_o, active_o} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs got=%h exp=0",
                 {tbuf_addr_o, font_addr_o, pixel_o, hsync_o, vsync_o, active_o});
      end
    end
    @(posedge clk_i);
    #5 rstn_i = 1'b1;
  endtask

  task automatic test_address_map();
    step(17, 35, 1'b1, 1'b1, 1'b1);
    @(posedge clk_i); #2;
    checks++;
    if (tbuf_addr_o !== 12'd162) begin
      errors++;
      $display("[TB] FAIL addr_map_tbuf got=%0d exp=162", tbuf_addr_o);
    end
    step(0, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk_i); #2;
    step(0, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk_i); #2;
    checks++;
    if (font_addr_o !== 11'h413) begin
      errors++;
      $display("[TB] FAIL addr_map_font got=%h exp=413", font_addr_o);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_pixel_select();
    logic [15:0] pixVec;
    pixVec = '0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) step(16 + i, 35, 1'b1, 1'b1, 1'b1);
      else        step(0, 0, 1'b0, 1'b1, 1'b1);
      @(posedge clk_i); #2;
      if (i >= 4) pixVec[i-4] = pixel_o;
    end
    checks++;
    if (pixVec[7:0] !== 8'b1000_0001) begin
      errors++;
      $display("[TB] FAIL pixel_select_normal got=%b exp=10000001", pixVec[7:0]);
    end
    checks++;
    if (pixVec[15:8] !== 8'b0111_1110) begin
      errors++;
      $display("[TB] FAIL pixel_select_inverse got=%b exp=01111110", pixVec[15:8]);
    end
  endtask

  task automatic test_blank_sync();
    logic [9:0] hsVec;
    logic       pixOr;
    hsVec = '0;
    pixOr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(8 * i + 3, 35, 1'b0, (i == 0) ? 1'b0 : 1'b1, 1'b1);
      else       step(0, 0, 1'b0, 1'b1, 1'b1);
      @(posedge clk_i); #2;
      hsVec[i] = hsync_o;
      pixOr    = pixOr | pixel_o;
    end
    checks++;
    if (hsVec !== 10'b11_1110_1111) begin
      errors++;
      $display("[TB] FAIL hsync_delay got=%b exp=1111101111", hsVec);
    end
    checks++;
    if (pixOr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL blank_pixel got=%b exp=0", pixOr);
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(639, 0), $urandom_range(479, 0), ($urandom_range(3, 0) != 0),
           1'($urandom), 1'b1);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 10; i++) step(16 + i, 40, 1'b1, 1'b1, 1'b1);
    #5 rstn_i = 1'b0;
    sbQ.delete();
`ifdef CURSOR_EN
    modelBlink  = 1'b0;
    modelFrame  = 0;
    modelPrevVs = 1'b0;
`endif
    #1;
    checks++;
    if ({tbuf_addr_o, font_addr_o, pixel_o, hsync_o, vsync_o, active_o} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got=%h exp=0",
               {tbuf_addr_o, font_addr_o, pixel_o, hsync_o, vsync_o, active_o});
    end
    @(posedge clk_i);
    @(posedge clk_i);
    #5 rstn_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(16 + i, 35, 1'b1, 1'b1, 1'b1);
      @(posedge clk_i); #2;
      if (i < 4) begin
        checks++;
        if ({pixel_o, hsync_o, vsync_o, active_o} !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL midreset_refill i=%0d got=%b exp=0000", i,
                   {pixel_o, hsync_o, vsync_o, active_o});
        end
      end
    end
  endtask

`ifdef CURSOR_EN
  task automatic test_cursor();
    logic [7:0] underline;
    for (int g = 13; g < 16; g++)
      for (int p = 0; p < 8; p++) step(16 + p, 32 + g, 1'b1, 1'b1, 1'b1);
    for (int f = 0; f < 15; f++) begin
      step(0, 0, 1'b0, 1'b1, 1'b0);
      step(0, 0, 1'b0, 1'b1, 1'b1);
    end
    for (int g = 13; g < 16; g++)
      for (int p = 0; p < 8; p++) step(16 + p, 32 + g, 1'b1, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    underline = '0;
    for (int p = 0; p < 12; p++) begin
      if (p < 8) step(16 + p, 46, 1'b1, 1'b1, 1'b1);
      else       step(0, 0, 1'b0, 1'b1, 1'b1);
      @(posedge clk_i); #2;
      if (p >= 4) underline[p-4] = pixel_o;
    end
    checks++;
    if (underline !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL cursor_underline got=%b exp=11111111", underline);
    end
    for (int g = 13; g < 16; g++)
      for (int p = 0; p < 8; p++) step(16 + p, 32 + g, 1'b1, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 4096; i++) tbufMem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) fontMem[i] = 8'($urandom);
    tbufMem[0]   = 8'h00;
    tbufMem[162] = 8'h41;
    tbufMem[163] = 8'hC1;
    for (int i = 0; i < 16; i++) fontMem[i] = 8'hFF;
    fontMem[11'h413] = 8'b1000_0001;
    fontMem[11'h41D] = 8'h00;
    fontMem[11'h41E] = 8'h00;
    fontMem[11'h41F] = 8'h00;
    rstn_i   = 1'b0;
    hcount_i = '0;
    vcount_i = '0;
    active_i = 1'b0;
    hsync_i  = 1'b1;
    vsync_i  = 1'b1;

    test_reset();
    test_address_map();
    test_pixel_select();
    test_blank_sync();
    test_random_stream();
    test_midframe_reset();
`ifdef CURSOR_EN
    test_cursor();
`endif

    repeat (4) @(posedge clk_i);
    #2;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
